// File: rtl/eth_tx_arbiter_if.sv
// Handshake and GMII bundle between the transmit sources and eth_tx_arbiter.
// master: arbiter side; slave: source / MAC side.
interface eth_tx_arbiter_if;
   logic [2:0]  req;
   logic [2:0]  grant;
   logic [2:0]  done;
   logic [2:0]  src_tx_en;
   logic [23:0] src_txd;
   logic        gmii_tx_en;
   logic [7:0]  gmii_txd;
   logic        busy;
   logic [1:0]  cur_src;
   logic        timeout_err;

   modport master (
      input  req, done, src_tx_en, src_txd,
      output grant, gmii_tx_en, gmii_txd, busy, cur_src, timeout_err
   );

   modport slave (
      output req, done, src_tx_en, src_txd,
      input  grant, gmii_tx_en, gmii_txd, busy, cur_src, timeout_err
   );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Round-robin GMII transmit arbiter for ARP / UDP / ICMP frame sources.
// One owner at a time drives GMII through a one-cycle register stage; a
// watchdog aborts stuck frames and an inter-frame gap is enforced on exit.
module eth_tx_arbiter #(
   parameter int unsigned IFG_CYCLES     = 12,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input logic              clk,
   input logic              rst,
   eth_tx_arbiter_if.master bus
);
   localparam logic [7:0]  IfgLimit     = 8'(IFG_CYCLES);
   localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);
   localparam logic [1:0]  SrcNone      = 2'b11;
   localparam logic [1:0]  SrcIcmp      = 2'd2;

   typedef enum logic [1:0] {StIdle, StGrant, StActive, StIfg} state_e;

   state_e      state;
   logic [1:0]  last_src;
   logic [1:0]  winner;
   logic [15:0] wdog_cnt;
   logic [15:0] wdog_next;
   logic [7:0]  gap_cnt;
   logic [7:0]  gap_next;
   logic        own_en;
   logic        own_done;
   logic [7:0]  own_txd;

   assign wdog_next = wdog_cnt + 16'd1;
   assign gap_next  = gap_cnt + 8'd1;

   // Round-robin pick: search starts at the source after last_src.
   always_comb begin
      winner = 2'd0;
      case (last_src)
         2'd0: begin
            if (bus.req[1])      winner = 2'd1;
            else if (bus.req[2]) winner = 2'd2;
            else                 winner = 2'd0;
         end
         2'd1: begin
            if (bus.req[2])      winner = 2'd2;
            else if (bus.req[0]) winner = 2'd0;
            else                 winner = 2'd1;
         end
         default: begin
            if (bus.req[0])      winner = 2'd0;
            else if (bus.req[1]) winner = 2'd1;
            else                 winner = 2'd2;
         end
      endcase
   end

   // Owner mux: only the current owner's enable, data and done are visible.
   always_comb begin
      own_en   = 1'b0;
      own_done = 1'b0;
      own_txd  = 8'h00;
      case (bus.cur_src)
         2'd0: begin
            own_en   = bus.src_tx_en[0];
            own_done = bus.done[0];
            own_txd  = bus.src_txd[7:0];
         end
         2'd1: begin
            own_en   = bus.src_tx_en[1];
            own_done = bus.done[1];
            own_txd  = bus.src_txd[15:8];
         end
         2'd2: begin
            own_en   = bus.src_tx_en[2];
            own_done = bus.done[2];
            own_txd  = bus.src_txd[23:16];
         end
         default: begin
            own_en   = 1'b0;
            own_done = 1'b0;
            own_txd  = 8'h00;
         end
      endcase
   end

   // Arbitration FSM; every output is registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= StIdle;
         last_src        <= SrcIcmp;
         wdog_cnt        <= 16'd0;
         gap_cnt         <= 8'd0;
         bus.grant       <= 3'b000;
         bus.gmii_tx_en  <= 1'b0;
         bus.gmii_txd    <= 8'h00;
         bus.busy        <= 1'b0;
         bus.cur_src     <= SrcNone;
         bus.timeout_err <= 1'b0;
      end else begin
         bus.grant       <= 3'b000;
         bus.timeout_err <= 1'b0;
         bus.gmii_tx_en  <= 1'b0;
         bus.gmii_txd    <= 8'h00;
         case (state)
            StIdle: begin
               if (|bus.req) begin
                  state       <= StGrant;
                  last_src    <= winner;
                  bus.cur_src <= winner;
                  bus.grant   <= 3'b001 << winner;
                  bus.busy    <= 1'b1;
               end
            end
            StGrant: begin
               state    <= StActive;
               wdog_cnt <= 16'd0;
               gap_cnt  <= 8'd0;
            end
            StActive: begin
               // The done cycle still forwards its byte; an abort cuts GMII at once.
               bus.gmii_tx_en <= own_en;
               bus.gmii_txd   <= own_txd;
               if (own_done) begin
                  state   <= StIfg;
                  gap_cnt <= 8'd0;
               end else if (wdog_next == TimeoutLimit) begin
                  state           <= StIfg;
                  gap_cnt         <= 8'd0;
                  bus.timeout_err <= 1'b1;
                  bus.gmii_tx_en  <= 1'b0;
                  bus.gmii_txd    <= 8'h00;
               end else begin
                  wdog_cnt <= wdog_next;
               end
            end
            StIfg: begin
               // Gap only counts while the owner is really silent.
               if (own_en) begin
                  gap_cnt <= 8'd0;
               end else if (gap_next == IfgLimit) begin
                  state       <= StIdle;
                  gap_cnt     <= 8'd0;
                  bus.busy    <= 1'b0;
                  bus.cur_src <= SrcNone;
               end else begin
                  gap_cnt <= gap_next;
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end
endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 Parameter IFG_CYCLES, default 12, minimum idle cycles on GMII between frames (range 1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, maximum ACTIVE cycles before forced abort (range 2..65535).
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req  in  3  level transmit requests; bit0 ARP, bit1 UDP, bit2 ICMP.
REQ-006 grant  out  3  one-hot single-cycle start pulse to the granted source (drives its tx start_en).
REQ-007 done  in  3  per-source tx_done pulses.
REQ-008 src_tx_en  in  3  per-source GMII tx enable.
REQ-009 src_txd  in  24  per-source GMII data; [7:0] ARP, [15:8] UDP, [23:16] ICMP.
REQ-010 gmii_tx_en  out  1  registered GMII tx enable to MAC/PHY.
REQ-011 gmii_txd  out  8  registered GMII tx data.
REQ-012 busy  out  1  high in any state except IDLE.
REQ-013 cur_src  out  2  owner: 00 ARP, 01 UDP, 10 ICMP, 11 none.
REQ-014 timeout_err  out  1  single-cycle pulse on watchdog abort.

Function
REQ-015 FSM states SHALL be IDLE, GRANT, ACTIVE, IFG.
REQ-016 IDLE: if req nonzero, select winner by round-robin starting at the source after last_src, latch cur_src, go GRANT; else stay.
REQ-017 last_src SHALL update to the winner at selection; with all three requesting continuously, service order SHALL be ARP, UDP, ICMP, ARP, ...
REQ-018 GRANT: assert grant[cur_src] for exactly one cycle, go ACTIVE; req changes after selection SHALL NOT alter cur_src.
REQ-019 ACTIVE: gmii_tx_en/gmii_txd SHALL follow src_tx_en[cur_src]/src_txd slice of cur_src with exactly one clk latency; non-owner inputs SHALL never reach GMII.
REQ-020 ACTIVE: done[cur_src]=1 -> IFG; done bits of non-owners SHALL be ignored in every state.
REQ-021 Watchdog: 16-bit counter cleared on GRANT, incremented each ACTIVE cycle; on reaching TIMEOUT_CYCLES without done, pulse timeout_err one cycle and go IFG.
REQ-022 Simultaneous done[cur_src] and timeout in the same cycle: done wins, no timeout_err.
REQ-023 IFG: gmii_tx_en=0, gmii_txd=0; 8-bit gap counter increments only on cycles with src_tx_en[cur_src]=0, clears when it is 1; on count reaching IFG_CYCLES -> IDLE.
REQ-024 In IDLE and GRANT, gmii_tx_en=0 and gmii_txd=0; cur_src=11 in IDLE, owner value in GRANT/ACTIVE/IFG.
REQ-025 Minimum spacing: last gmii_tx_en=1 cycle of a frame to first gmii_tx_en=1 of next frame SHALL be at least IFG_CYCLES+3 clk cycles.
REQ-026 A req dropped before selection SHALL NOT be granted; a req held during another owner's frame SHALL be served after IFG, not lost.

Reset
REQ-027 rst=1 at a clock edge SHALL force: state IDLE, grant=000, gmii_tx_en=0, gmii_txd=00, busy=0, cur_src=11, timeout_err=0, counters 0, last_src=ICMP (so ARP wins first).
REQ-028 Reset mid-frame SHALL abort immediately; no grant or GMII activity until the first cycle after rst deasserts, then normal IDLE arbitration.

Verification
REQ-029 Single UDP req=010, source drives 60 bytes then done -> grant=010 one cycle after req sampled, gmii mirrors src_txd[15:8] delayed 1 cycle, 60 bytes exact, busy low 12 cycles after src_tx_en drops.
REQ-030 req=111 held for 4 frames -> grant order 001,010,100,001; each frame gap >= 15 cycles of gmii_tx_en=0.
REQ-031 ARP frame in progress, ICMP raises req and pulses done[2] -> ICMP data never on GMII, frame uninterrupted, ICMP granted after ARP IFG.
REQ-032 TIMEOUT_CYCLES=16, owner never asserts done -> timeout_err pulse at 16th ACTIVE cycle, gmii_tx_en=0 from next cycle, return to IDLE after IFG.
REQ-033 rst asserted 20 bytes into a UDP frame -> next cycle gmii_tx_en=0, cur_src=11; after release with req=011, grant=001 first.
REQ-034 done[cur_src] and timeout coincide (TIMEOUT_CYCLES=16, done at cycle 16) -> IFG entered, timeout_err stays 0.
